// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_pkg
//  Description : Shared defaults and types for the regfile writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam int c_WB_DEPTH   = 4;
    localparam int c_STARVE_MAX = 8;
    localparam int c_AW         = 5;
    localparam int c_DW         = 32;

    // Value the write-data register holds out of reset.
    localparam logic [c_DW-1:0] c_ZERO = '0;

    // Writeback source chosen for the current cycle.
    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_FIFO = 2'd2
    } wb_sel_e;

endpackage : regfile_wb_arbiter_pkg
`default_nettype wire

// File: rtl/regfile_wb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_fifo
//  Description : Multi-cycle result queue (addr+data per entry) with
//                per-entry address compare for hazard queries.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = c_WB_DEPTH,
    parameter int AW    = c_AW,
    parameter int DW    = c_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [AW-1:0] i_push_addr,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [AW-1:0] o_head_addr,
    output logic [DW-1:0] o_head_data,
    output logic          o_full,
    output logic          o_empty,
    input  logic [AW-1:0] i_chk_addr1,
    input  logic [AW-1:0] i_chk_addr2,
    output logic          o_hit1,
    output logic          o_hit2
);

    localparam int c_PW = $clog2(DEPTH);

    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW:0]    r_count;
    logic [AW-1:0]    r_addr_mem [DEPTH];
    logic [DW-1:0]    r_data_mem [DEPTH];
    logic [DEPTH-1:0] w_match1;
    logic [DEPTH-1:0] w_match2;

    assign o_full      = (r_count == (c_PW+1)'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_head_addr = r_addr_mem[r_rd_ptr];
    assign o_head_data = r_data_mem[r_rd_ptr];
    assign o_hit1      = |w_match1;
    assign o_hit2      = |w_match2;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (c_PW+1)'(1);
                2'b01:   r_count <= r_count - (c_PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are qualified by occupancy, so no reset needed.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr_mem[r_wr_ptr] <= i_push_addr;
            r_data_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam logic [c_PW-1:0] c_IDX = c_PW'(i);
        logic [c_PW-1:0] w_offset;
        logic            w_valid;
        assign w_offset    = c_IDX - r_rd_ptr;
        assign w_valid     = ({1'b0, w_offset} < r_count);
        assign w_match1[i] = w_valid && (r_addr_mem[i] == i_chk_addr1);
        assign w_match2[i] = w_valid && (r_addr_mem[i] == i_chk_addr2);
    end

endmodule : regfile_wb_arbiter_fifo
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Merges the ALU writeback slot with queued multi-cycle results
//                into one registered regfile write per cycle; exposes pending
//                flags for hazard detection and a starvation stall request.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = c_WB_DEPTH,
    parameter int STARVE_MAX = c_STARVE_MAX,
    parameter int AW         = c_AW,
    parameter int DW         = c_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_waddr,
    input  logic [DW-1:0] alu_wdata,
    input  logic          mc_valid,
    output logic          mc_ready,
    input  logic [AW-1:0] mc_waddr,
    input  logic [DW-1:0] mc_wdata,
    input  logic [AW-1:0] chk_addr1,
    input  logic [AW-1:0] chk_addr2,
    output logic          chk_busy1,
    output logic          chk_busy2,
    output logic          stall_req,
    output logic          wif,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wresult
);

    localparam int            c_SW    = $clog2(STARVE_MAX) + 1;
    localparam logic [c_SW-1:0] c_SLIM = c_SW'(STARVE_MAX - 1);

    wb_sel_e         w_sel;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_hit1;
    logic            w_hit2;
    logic [AW-1:0]   w_head_addr;
    logic [DW-1:0]   w_head_data;
    logic [c_SW-1:0] r_starve_cnt;
    logic            r_stall_req;

    // mc_ready is forced low while reset is held, not just on a full queue.
    assign mc_ready  = rst && !w_full;
    assign w_push    = mc_valid && mc_ready;
    assign w_pop     = (w_sel == SEL_FIFO);
    assign chk_busy1 = (chk_addr1 != '0) && w_hit1;
    assign chk_busy2 = (chk_addr2 != '0) && w_hit2;
    assign stall_req = r_stall_req;

    regfile_wb_arbiter_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_addr (mc_waddr),
        .i_push_data (mc_wdata),
        .i_pop       (w_pop),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .i_chk_addr1 (chk_addr1),
        .i_chk_addr2 (chk_addr2),
        .o_hit1      (w_hit1),
        .o_hit2      (w_hit2)
    );

    // Fixed priority source select: ALU, then queue head, else idle.
    always_comb begin
        w_sel = SEL_IDLE;
        if (alu_valid)     w_sel = SEL_ALU;
        else if (!w_empty) w_sel = SEL_FIFO;
    end

    // Registered regfile write port; register 0 is consumed without a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wif     <= 1'b0;
            waddr   <= '0;
            wresult <= DW'(c_ZERO);
        end else begin
            case (w_sel)
                SEL_ALU: begin
                    wif     <= (alu_waddr != '0);
                    waddr   <= alu_waddr;
                    wresult <= alu_wdata;
                end
                SEL_FIFO: begin
                    wif     <= (w_head_addr != '0);
                    waddr   <= w_head_addr;
                    wresult <= w_head_data;
                end
                default: wif <= 1'b0;
            endcase
        end
    end

    // Count cycles the queue head is blocked by ALU writes; request a stall
    // once it has waited STARVE_MAX cycles, and hold it until the head pops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
            r_stall_req  <= 1'b0;
        end else if (w_pop || w_empty) begin
            r_starve_cnt <= '0;
            r_stall_req  <= 1'b0;
        end else if (alu_valid) begin
            if (r_starve_cnt == c_SLIM) r_stall_req  <= 1'b1;
            else                        r_starve_cnt <= r_starve_cnt + c_SW'(1);
        end
    end

endmodule : regfile_wb_arbiter
`default_nettype wire
